// File: rtl/lfsr_checker.sv
// Receive-side checker for the 32-bit Fibonacci PRBS (taps 27,23,19,18,15,11,7,4,1).
// Hunts for 32 received bits, then predicts each bit, counts mismatches and re-hunts on excess errors.
`timescale 1ns/1ps
module lfsr_checker #(
    parameter int LOSS_THRESH = 8,
    parameter int WINDOW      = 64
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        valid_i,
    input  logic        bit_i,
    input  logic        clear_i,
    output logic        locked_o,
    output logic        err_o,
    output logic [15:0] err_count_o,
    output logic [31:0] checked_count_o,
    output logic [31:0] state_o
);

    localparam int          WIN_W    = $clog2(WINDOW);
    localparam int          WERR_W   = $clog2(WINDOW + 1);
    localparam logic [31:0] TAP_MASK = 32'h088C_8892;

    typedef enum logic {HUNT, LOCKED} fsm_t;

    fsm_t              fsm_reg, fsm_next;
    logic [31:0]       lfsr_reg, lfsr_next;
    logic [4:0]        fill_reg, fill_next;
    logic [WIN_W-1:0]  win_cnt_reg, win_cnt_next;
    logic [WERR_W-1:0] win_err_reg, win_err_next;
    logic              err_reg, err_next;
    logic [15:0]       err_count_reg, err_count_next;
    logic [31:0]       checked_count_reg, checked_count_next;

    logic [31:0]       tapped;
    logic              predict;
    logic              mismatch;
    logic [31:0]       hunt_shift;
    logic [WERR_W-1:0] win_err_inc;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_tap
            assign tapped[gi] = lfsr_reg[gi] & TAP_MASK[gi];
        end
    endgenerate

    assign predict     = ^tapped;
    assign mismatch    = bit_i ^ predict;
    assign hunt_shift  = {lfsr_reg[30:0], bit_i};
    assign win_err_inc = win_err_reg + WERR_W'(1);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fsm_reg           <= HUNT;
            lfsr_reg          <= '0;
            fill_reg          <= '0;
            win_cnt_reg       <= '0;
            win_err_reg       <= '0;
            err_reg           <= 1'b0;
            err_count_reg     <= '0;
            checked_count_reg <= '0;
        end else begin
            fsm_reg           <= fsm_next;
            lfsr_reg          <= lfsr_next;
            fill_reg          <= fill_next;
            win_cnt_reg       <= win_cnt_next;
            win_err_reg       <= win_err_next;
            err_reg           <= err_next;
            err_count_reg     <= err_count_next;
            checked_count_reg <= checked_count_next;
        end
    end

    always_comb begin
        fsm_next           = fsm_reg;
        lfsr_next          = lfsr_reg;
        fill_next          = fill_reg;
        win_cnt_next       = win_cnt_reg;
        win_err_next       = win_err_reg;
        err_next           = 1'b0;
        err_count_next     = err_count_reg;
        checked_count_next = checked_count_reg;

        if (valid_i) begin
            case (fsm_reg)
                HUNT: begin
                    lfsr_next = hunt_shift;
                    // 5-bit fill wraps 31 -> 0 on its own; an all-zero load is the lock-up state
                    fill_next = fill_reg + 5'd1;
                    if (fill_reg == 5'd31 && hunt_shift != 32'd0) begin
                        fsm_next = LOCKED;
                    end
                end
                LOCKED: begin
                    // Advance on the prediction so a flipped bit cannot corrupt later predictions
                    lfsr_next          = {lfsr_reg[30:0], predict};
                    checked_count_next = checked_count_reg + 32'd1;
                    win_cnt_next       = win_cnt_reg + WIN_W'(1);
                    err_next           = mismatch;
                    if (mismatch && err_count_reg != 16'hFFFF) begin
                        err_count_next = err_count_reg + 16'd1;
                    end
                    if (mismatch && win_err_inc == WERR_W'(LOSS_THRESH)) begin
                        fsm_next     = HUNT;
                        fill_next    = '0;
                        win_cnt_next = '0;
                        win_err_next = '0;
                    end else if (win_cnt_reg == WIN_W'(WINDOW - 1)) begin
                        win_err_next = '0;
                    end else if (mismatch) begin
                        win_err_next = win_err_inc;
                    end
                end
                default: fsm_next = HUNT;
            endcase
        end

        if (clear_i) begin
            err_count_next     = '0;
            checked_count_next = '0;
        end
    end

    assign locked_o        = (fsm_reg == LOCKED);
    assign err_o           = err_reg;
    assign err_count_o     = err_count_reg;
    assign checked_count_o = checked_count_reg;
    assign state_o         = lfsr_reg;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: randomized PRBS stimulus, bit-history reference model,
// per-cycle expected values queued by the driver and popped by an independent monitor.
`timescale 1ns/1ps
module tb_lfsr_checker;

    localparam int LOSS_THRESH = 8;
    localparam int WINDOW      = 64;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        bit_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        locked_o;
    logic        err_o;
    logic [15:0] err_count_o;
    logic [31:0] checked_count_o;
    logic [31:0] state_o;

    always #5 clk = ~clk;

    lfsr_checker #(.LOSS_THRESH(LOSS_THRESH), .WINDOW(WINDOW)) dut (
        .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .bit_i(bit_i), .clear_i(clear_i),
        .locked_o(locked_o), .err_o(err_o), .err_count_o(err_count_o),
        .checked_count_o(checked_count_o), .state_o(state_o)
    );

    typedef struct packed {
        logic        locked;
        logic        err;
        logic [15:0] ec;
        logic [31:0] cc;
        logic [31:0] st;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    // Reference model: history of the last 32 sequence bits, hist[k] = bit emitted k steps ago
    int          taps[9] = '{27, 23, 19, 18, 15, 11, 7, 4, 1};
    bit          hist[$];
    bit          m_locked;
    bit          m_err;
    int          m_fill, m_winpos, m_winerr, m_errcnt;
    logic [31:0] m_chk;

    logic [31:0] gen_state;
    logic [31:0] gen_mask;

    function automatic logic [31:0] pack_hist();
        logic [31:0] r;
        for (int k = 0; k < 32; k++) r[k] = hist[k];
        return r;
    endfunction

    function automatic logic gen_bit();
        logic nb;
        nb = ^(gen_state & gen_mask);
        gen_state = {gen_state[30:0], nb};
        return nb;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < 32; k++) hist.push_back(1'b0);
        m_locked = 0; m_err = 0; m_fill = 0; m_winpos = 0; m_winerr = 0; m_errcnt = 0; m_chk = '0;
    endtask

    task automatic model_step(input logic v, input logic b, input logic c, input logic r);
        bit p, mis;
        if (r) begin
            model_reset();
            return;
        end
        m_err = 0;
        if (v) begin
            if (!m_locked) begin
                hist.push_front(b);
                void'(hist.pop_back());
                m_fill++;
                if (m_fill == 32) begin
                    m_fill = 0;
                    if (pack_hist() != 32'd0) m_locked = 1;
                end
            end else begin
                p = 0;
                foreach (taps[i]) p ^= hist[taps[i]];
                mis = (b != p);
                hist.push_front(p);
                void'(hist.pop_back());
                m_chk++;
                m_winpos++;
                if (mis) begin
                    if (m_errcnt < 65535) m_errcnt++;
                    m_winerr++;
                    m_err = 1;
                end
                if (mis && m_winerr == LOSS_THRESH) begin
                    m_locked = 0; m_fill = 0; m_winpos = 0; m_winerr = 0;
                end else if (m_winpos == WINDOW) begin
                    m_winpos = 0; m_winerr = 0;
                end
            end
        end
        if (c) begin
            m_errcnt = 0;
            m_chk = '0;
        end
    endtask

    task automatic drive(input logic v, input logic b, input logic c, input logic r);
        exp_t e;
        @(negedge clk);
        valid_i = v; bit_i = b; clear_i = c; reset_i = r;
        model_step(v, b, c, r);
        e.locked = m_locked;
        e.err    = m_err;
        e.ec     = m_errcnt[15:0];
        e.cc     = m_chk;
        e.st     = pack_hist();
        exp_q.push_back(e);
    endtask

    task automatic clean(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, gen_bit(), 1'b0, 1'b0);
    endtask

    task automatic bad();
        drive(1'b1, ~gen_bit(), 1'b0, 1'b0);
    endtask

    task automatic align();
        while (m_winpos != 0) clean(1);
    endtask

    task automatic peek();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: one expected entry per driven cycle, compared after the consuming edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                txn++;
                if ({locked_o, err_o, err_count_o, checked_count_o, state_o} !== e) begin
                    errors++;
                    $display("FAIL scoreboard txn %0d: got lock=%b err=%b ec=%0d cc=%0d st=%h expected lock=%b err=%b ec=%0d cc=%0d st=%h",
                             txn, locked_o, err_o, err_count_o, checked_count_o, state_o,
                             e.locked, e.err, e.ec, e.cc, e.st);
                end else begin
                    $display("txn %0d ok lock=%b err=%b ec=%0d cc=%0d st=%h",
                             txn, locked_o, err_o, err_count_o, checked_count_o, state_o);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int nvalid;
        gen_mask = '0;
        foreach (taps[i]) gen_mask[taps[i]] = 1'b1;
        model_reset();

        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        peek();
        check("reset_locked", {31'd0, locked_o}, 32'd0);
        check("reset_err", {31'd0, err_o}, 32'd0);
        check("reset_ec", {16'd0, err_count_o}, 32'd0);
        check("reset_cc", checked_count_o, 32'd0);
        check("reset_state", state_o, 32'd0);

        // Lock-up
        gen_state = 32'd12403709;
        clean(31);
        peek();
        check("hunt31_locked", {31'd0, locked_o}, 32'd0);
        clean(1);
        peek();
        check("lock32_locked", {31'd0, locked_o}, 32'd1);
        clean(10000);
        peek();
        check("run_ec", {16'd0, err_count_o}, 32'd0);
        check("run_cc", checked_count_o, 32'd10000);
        check("run_state", state_o, gen_state);

        // Single error
        bad();
        peek();
        check("single_err", {31'd0, err_o}, 32'd1);
        check("single_ec", {16'd0, err_count_o}, 32'd1);
        check("single_locked", {31'd0, locked_o}, 32'd1);
        clean(300);
        peek();
        check("single_after_ec", {16'd0, err_count_o}, 32'd1);

        // Loss: 8 errors inside one window
        drive(1'b1, gen_bit(), 1'b1, 1'b0);
        align();
        for (int i = 0; i < 7; i++) begin
            bad();
            clean(1);
        end
        bad();
        peek();
        check("loss_locked", {31'd0, locked_o}, 32'd0);
        check("loss_err", {31'd0, err_o}, 32'd1);
        check("loss_ec", {16'd0, err_count_o}, 32'd8);
        clean(31);
        peek();
        check("relock31_locked", {31'd0, locked_o}, 32'd0);
        clean(1);
        peek();
        check("relock_locked", {31'd0, locked_o}, 32'd1);
        check("relock_ec", {16'd0, err_count_o}, 32'd8);

        // Window edge: 7 + 7 across a boundary holds lock
        align();
        clean(57);
        for (int i = 0; i < 14; i++) bad();
        peek();
        check("edge_hold_locked", {31'd0, locked_o}, 32'd1);
        check("edge_hold_ec", {16'd0, err_count_o}, 32'd22);
        clean(57);
        for (int i = 0; i < 7; i++) bad();
        clean(56);
        bad();
        peek();
        check("edge_loss_locked", {31'd0, locked_o}, 32'd0);
        clean(32);
        peek();
        check("edge_relock", {31'd0, locked_o}, 32'd1);

        // Clear coincident with an error
        drive(1'b1, ~gen_bit(), 1'b1, 1'b0);
        peek();
        check("clear_err", {31'd0, err_o}, 32'd1);
        check("clear_ec", {16'd0, err_count_o}, 32'd0);
        check("clear_cc", checked_count_o, 32'd0);

        // Random errors, clears and gaps
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) bad();
            else if (r < 3) drive(1'b1, gen_bit(), 1'b1, 1'b0);
            else if (r < 15) drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            else clean(1);
        end

        // Reset mid-LOCKED
        clean(40);
        peek();
        check("prereset_locked", {31'd0, locked_o}, 32'd1);
        drive(1'b1, gen_bit(), 1'b0, 1'b1);
        peek();
        check("midreset_locked", {31'd0, locked_o}, 32'd0);
        check("midreset_ec", {16'd0, err_count_o}, 32'd0);
        check("midreset_cc", checked_count_o, 32'd0);
        check("midreset_state", state_o, 32'd0);
        clean(31);
        peek();
        check("postreset31_locked", {31'd0, locked_o}, 32'd0);
        clean(1);
        peek();
        check("postreset32_locked", {31'd0, locked_o}, 32'd1);

        // Zero stream never locks
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 100; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
        peek();
        check("zero_locked", {31'd0, locked_o}, 32'd0);
        check("zero_ec", {16'd0, err_count_o}, 32'd0);

        // Clean stream with random gaps matches the gapless result
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        gen_state = 32'd12403709;
        nvalid = 0;
        while (nvalid < 2000) begin
            if ($urandom_range(0, 3) == 0) drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            else begin
                clean(1);
                nvalid++;
            end
        end
        peek();
        check("gap_locked", {31'd0, locked_o}, 32'd1);
        check("gap_ec", {16'd0, err_count_o}, 32'd0);
        check("gap_cc", checked_count_o, 32'd1968);
        check("gap_state", state_o, gen_state);

        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
